riscv_operand_stage: RTL and testbench
======================================

// Module: riscv_operand_stage
// PURPOSE
// Registered operand-select stage between decode and execute. Generalises the OP1 mux: selects
// both ALU operands and the store-data word, with forwarding from NUM_FWD younger stages.
// Detects load-use hazards and stalls upstream through a valid/ready handshake.
// Counts hazard-stall cycles for performance monitoring.
// PARAMETERS
// WORD_LENGTH  32  datapath width in bits
// REG_ADDR_W   5   register-index width
// NUM_FWD      3   forwarding sources; index 0 = youngest = highest priority
// CNT_W        32  width of the stall counter
// PORTS
// clk          in   1                  clock
// rst_n        in   1                  synchronous reset, active-low
// in_valid     in   1                  decode presents an instruction
// in_ready     out  1                  stage accepts this cycle
// op1_sel      in   OP1_SEL            OP1_RS1 / OP1_PC / OP1_IMZ
// op2_sel      in   OP2_SEL            OP2_RS2 / OP2_IMM
// rs1_use      in   1                  rs1 value is architecturally needed
// rs2_use      in   1                  rs2 value needed (ALU or store data)
// rs1_addr     in   REG_ADDR_W         source register 1 index
// rs2_addr     in   REG_ADDR_W         source register 2 index
// rs1_data     in   WORD_LENGTH        regfile read data 1
// rs2_data     in   WORD_LENGTH        regfile read data 2
// pc           in   WORD_LENGTH        instruction PC
// imm_z_uext   in   WORD_LENGTH        zero-extended CSR immediate
// imm          in   WORD_LENGTH        sign-extended I/S/U/J immediate
// fwd_valid    in   NUM_FWD            source i writes a register
// fwd_pending  in   NUM_FWD            source i result not yet available (load in flight)
// fwd_rd       in   NUM_FWD*REG_ADDR_W destination index per source, packed with i=0 in the LSBs
// fwd_data     in   NUM_FWD*WORD_LENGTH result per source, packed with i=0 in the LSBs
// flush        in   1                  kill the stage contents (branch/trap)
// out_valid    out  1                  operands valid to execute
// out_ready    in   1                  execute consumes this cycle
// op1          out  WORD_LENGTH        selected operand 1
// op2          out  WORD_LENGTH        selected operand 2
// store_data   out  WORD_LENGTH        forwarded rs2 value
// stall_count  out  CNT_W              saturating count of hazard-stall cycles
// BEHAVIOUR
// - Resolution is per source register rsN:
//   - addr==0 gives value 0 and no hazard.
//   - Otherwise take the lowest i with fwd_valid[i] && fwd_rd[i]==addr.
//   - If that source has fwd_pending[i]=1, hzN=1; lower-priority matches are ignored.
//   - Else the value is fwd_data[i]. With no match, the value is rsN_data.
// - hazard = (rs1_use&hz1) | (rs2_use&hz2). An unused operand never stalls.
// - op1 select: OP1_RS1->fwd rs1, OP1_PC->pc, OP1_IMZ->imm_z_uext, any other code->0.
// - op2 select: OP2_RS2->fwd rs2, OP2_IMM->imm, any other code->0.
// - store_data is always the forwarded rs2 value.
// - in_ready = rst_n & !flush & !hazard & (!out_valid | out_ready). It is combinational.
// - Accept (in_valid&in_ready): op1/op2/store_data are registered and out_valid<=1 next edge.
//   Latency is 1 cycle.
// - No accept and out_ready=1: out_valid<=0. Data registers hold their value.
// - out_valid=1 and out_ready=0: all outputs hold stable (backpressure).
// - Simultaneous drain and accept gives back-to-back transfer: out_valid stays 1 with new data.
// - flush: out_valid<=0 next edge and nothing is captured that cycle. Flush wins over accept.
// - stall_count increments when in_valid & hazard & !flush, and saturates at all-ones.
// - rst_n=0 at an edge, including mid-transfer or mid-stall:
//   - out_valid=0, op1=op2=store_data=0, stall_count=0.
//   - in_ready=0 while rst_n is low.
// STRUCTURE
// - riscv_constants.sv package: add OP2_SEL enum {OP2_X, OP2_RS2, OP2_IMM} next to OP1_SEL.
// - Package also gets a shared REG_ZERO localparam.
// - Sub-module riscv_fwd_resolve: one per source register, instantiated twice.
//   - Combinational priority match.
//   - Outputs value and hazard.
// - The top module holds the selects, the handshake register and the counter.
// TESTING
// - No match:
//   - rs1_addr=5, rs1_data=0x11, op1_sel=OP1_RS1, fwd_valid=0.
//   - Expect op1=0x11 and out_valid=1 one cycle after accept.
// - Priority:
//   - fwd0 and fwd2 both write x7 with data 0xA/0xC, rs2_use=1, op2_sel=OP2_RS2.
//   - Expect op2=0xA and store_data=0xA.
// - Load-use:
//   - fwd0 writes x3 with pending=1, rs1_use=1.
//   - Expect in_ready=0 for 2 cycles and stall_count=2.
//   - Then pending=0, data 0x55: accept and op1=0x55.
//   - Unused rs1 with the same pending write: no stall.
// - x0 and default: rs1_addr=0 with fwd0 writing x0 data 0xFF gives op1=0.
//   - op1_sel=OP1_PC gives op1=pc.
//   - Illegal op2_sel gives op2=0.
// - Backpressure: out_ready=0 for 3 cycles, so outputs hold and in_ready=0.
//   - Then out_ready=1 with in_valid=1: back-to-back transfer with no bubble.
// - Flush/reset:
//   - flush together with in_valid: out_valid=0 next cycle.
//   - rst_n=0 mid-stall: all outputs 0 next edge, including stall_count.

Source files
------------

// File: rtl/riscv_constants.sv
// Shared RISC-V pipeline constants: operand-select encodings and the hard-wired zero register.
package riscv_constants;

   typedef enum logic [1:0] {
      OP1_X   = 2'd0,
      OP1_RS1 = 2'd1,
      OP1_PC  = 2'd2,
      OP1_IMZ = 2'd3
   } OP1_SEL;

   typedef enum logic [1:0] {
      OP2_X   = 2'd0,
      OP2_RS2 = 2'd1,
      OP2_IMM = 2'd2
   } OP2_SEL;

   localparam int REG_ZERO = 0;

endpackage

// File: rtl/riscv_fwd_resolve.sv
// Per-source-register forwarding resolution: lowest-index (youngest) matching producer wins.
module riscv_fwd_resolve
   import riscv_constants::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int NUM_FWD     = 3
) (
   input  logic [REG_ADDR_W-1:0]          addr_i,
   input  logic [WORD_LENGTH-1:0]         rf_data_i,
   input  logic [NUM_FWD-1:0]             fwd_valid_i,
   input  logic [NUM_FWD-1:0]             fwd_pending_i,
   input  logic [NUM_FWD*REG_ADDR_W-1:0]  fwd_rd_i,
   input  logic [NUM_FWD*WORD_LENGTH-1:0] fwd_data_i,
   output logic [WORD_LENGTH-1:0]         value_o,
   output logic                           hazard_o
);

   always_comb begin
      value_o  = rf_data_i;
      hazard_o = 1'b0;
      // Walk oldest to youngest so the youngest match is the last assignment standing.
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_valid_i[i] && (fwd_rd_i[i*REG_ADDR_W +: REG_ADDR_W] == addr_i)) begin
            value_o  = fwd_data_i[i*WORD_LENGTH +: WORD_LENGTH];
            hazard_o = fwd_pending_i[i];
         end
      end
      if (addr_i == REG_ADDR_W'(REG_ZERO)) begin
         value_o  = '0;
         hazard_o = 1'b0;
      end
   end

endmodule

// File: rtl/riscv_operand_stage.sv
// Registered operand-select stage: forwards rs1/rs2, selects ALU operands and store data,
// stalls decode on load-use hazards and counts the stall cycles.
module riscv_operand_stage
   import riscv_constants::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int NUM_FWD     = 3,
   parameter int CNT_W       = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  OP1_SEL                         op1_sel,
   input  OP2_SEL                         op2_sel,
   input  logic                           rs1_use,
   input  logic                           rs2_use,
   input  logic [REG_ADDR_W-1:0]          rs1_addr,
   input  logic [REG_ADDR_W-1:0]          rs2_addr,
   input  logic [WORD_LENGTH-1:0]         rs1_data,
   input  logic [WORD_LENGTH-1:0]         rs2_data,
   input  logic [WORD_LENGTH-1:0]         pc,
   input  logic [WORD_LENGTH-1:0]         imm_z_uext,
   input  logic [WORD_LENGTH-1:0]         imm,
   input  logic [NUM_FWD-1:0]             fwd_valid,
   input  logic [NUM_FWD-1:0]             fwd_pending,
   input  logic [NUM_FWD*REG_ADDR_W-1:0]  fwd_rd,
   input  logic [NUM_FWD*WORD_LENGTH-1:0] fwd_data,
   input  logic                           flush,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WORD_LENGTH-1:0]         op1,
   output logic [WORD_LENGTH-1:0]         op2,
   output logic [WORD_LENGTH-1:0]         store_data,
   output logic [CNT_W-1:0]               stall_count
);

   logic [WORD_LENGTH-1:0] rs1_fwd, rs2_fwd;
   logic                   hz1, hz2, hazard, accept, stall_inc;
   logic [WORD_LENGTH-1:0] op1_d, op2_d;

   logic                   out_valid_q;
   logic [WORD_LENGTH-1:0] op1_q, op2_q, store_data_q;
   logic [CNT_W-1:0]       stall_count_q;

   riscv_fwd_resolve #(
      .WORD_LENGTH (WORD_LENGTH),
      .REG_ADDR_W  (REG_ADDR_W),
      .NUM_FWD     (NUM_FWD)
   ) u_rs1 (
      .addr_i        (rs1_addr),
      .rf_data_i     (rs1_data),
      .fwd_valid_i   (fwd_valid),
      .fwd_pending_i (fwd_pending),
      .fwd_rd_i      (fwd_rd),
      .fwd_data_i    (fwd_data),
      .value_o       (rs1_fwd),
      .hazard_o      (hz1)
   );

   riscv_fwd_resolve #(
      .WORD_LENGTH (WORD_LENGTH),
      .REG_ADDR_W  (REG_ADDR_W),
      .NUM_FWD     (NUM_FWD)
   ) u_rs2 (
      .addr_i        (rs2_addr),
      .rf_data_i     (rs2_data),
      .fwd_valid_i   (fwd_valid),
      .fwd_pending_i (fwd_pending),
      .fwd_rd_i      (fwd_rd),
      .fwd_data_i    (fwd_data),
      .value_o       (rs2_fwd),
      .hazard_o      (hz2)
   );

   assign hazard    = (rs1_use & hz1) | (rs2_use & hz2);
   assign in_ready  = rst_n & ~flush & ~hazard & (~out_valid_q | out_ready);
   assign accept    = in_valid & in_ready;
   assign stall_inc = in_valid & hazard & ~flush;

   always_comb begin
      op1_d = '0;
      case (op1_sel)
         OP1_RS1: op1_d = rs1_fwd;
         OP1_PC:  op1_d = pc;
         OP1_IMZ: op1_d = imm_z_uext;
         default: op1_d = '0;
      endcase
   end

   always_comb begin
      op2_d = '0;
      case (op2_sel)
         OP2_RS2: op2_d = rs2_fwd;
         OP2_IMM: op2_d = imm;
         default: op2_d = '0;
      endcase
   end

   // Flush outranks accept; in_ready already excludes flush, so accept cannot fire with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         op1_q         <= '0;
         op2_q         <= '0;
         store_data_q  <= '0;
         stall_count_q <= '0;
      end else begin
         if (flush) begin
            out_valid_q <= 1'b0;
         end else if (accept) begin
            out_valid_q  <= 1'b1;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            store_data_q <= rs2_fwd;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (stall_inc && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign op1         = op1_q;
   assign op2         = op2_q;
   assign store_data  = store_data_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_riscv_operand_stage.sv
// Self-checking bench for riscv_operand_stage: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_riscv_operand_stage;
   import riscv_constants::*;

   localparam int W = 32;
   localparam int A = 5;
   localparam int N = 3;
   localparam int C = 32;
   localparam logic [W-1:0] PC_V  = 32'h0000_1000;
   localparam logic [W-1:0] IMM_V = 32'h0000_07FF;
   localparam logic [W-1:0] IMZ_V = 32'h0000_001F;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid, in_ready, in_ready_s;
   OP1_SEL         op1_sel;
   OP2_SEL         op2_sel;
   logic           rs1_use, rs2_use;
   logic [A-1:0]   rs1_addr, rs2_addr;
   logic [W-1:0]   rs1_data, rs2_data, pc, imm_z_uext, imm;
   logic [N-1:0]   fwd_valid, fwd_pending;
   logic [N*A-1:0] fwd_rd;
   logic [N*W-1:0] fwd_data;
   logic           flush;
   logic           out_valid, out_valid_s, out_ready;
   logic [W-1:0]   op1, op2, store_data, op1_s, op2_s, store_data_s;
   logic [C-1:0]   stall_count;
   logic [2:0]     stall_count_s;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   riscv_operand_stage #(.WORD_LENGTH(W), .REG_ADDR_W(A), .NUM_FWD(N), .CNT_W(C)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op1_sel(op1_sel), .op2_sel(op2_sel), .rs1_use(rs1_use), .rs2_use(rs2_use),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .pc(pc), .imm_z_uext(imm_z_uext), .imm(imm), .fwd_valid(fwd_valid),
      .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2),
      .store_data(store_data), .stall_count(stall_count)
   );

   // Narrow-counter instance so saturation is reachable in a short run.
   riscv_operand_stage #(.WORD_LENGTH(W), .REG_ADDR_W(A), .NUM_FWD(N), .CNT_W(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .op1_sel(op1_sel), .op2_sel(op2_sel), .rs1_use(rs1_use), .rs2_use(rs2_use),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .pc(pc), .imm_z_uext(imm_z_uext), .imm(imm), .fwd_valid(fwd_valid),
      .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
      .out_valid(out_valid_s), .out_ready(out_ready), .op1(op1_s), .op2(op2_s),
      .store_data(store_data_s), .stall_count(stall_count_s)
   );

   typedef struct {
      logic [1:0]     s1, s2;
      logic [A-1:0]   a1, a2;
      logic [W-1:0]   d1, d2;
      logic [N-1:0]   fv;
      logic [N*A-1:0] frd;
      logic [N*W-1:0] fdat;
      logic [W-1:0]   e1, e2, esd;
      string          name;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid    = 1'b0;
      flush       = 1'b0;
      out_ready   = 1'b1;
      op1_sel     = OP1_RS1;
      op2_sel     = OP2_RS2;
      rs1_use     = 1'b0;
      rs2_use     = 1'b0;
      rs1_addr    = '0;
      rs2_addr    = '0;
      rs1_data    = 32'h11;
      rs2_data    = 32'h22;
      pc          = PC_V;
      imm         = IMM_V;
      imm_z_uext  = IMZ_V;
      fwd_valid   = '0;
      fwd_pending = '0;
      fwd_rd      = '0;
      fwd_data    = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Reference: youngest matching producer supplies the value or, if pending, a hazard.
   function automatic void ref_resolve(input logic [A-1:0] addr, input logic [W-1:0] rf,
                                       output logic [W-1:0] val, output bit hz);
      val = rf;
      hz  = 1'b0;
      if (addr == 0) begin
         val = '0;
         return;
      end
      for (int i = 0; i < N; i++) begin
         if (fwd_valid[i] && fwd_rd[i*A +: A] == addr) begin
            val = fwd_data[i*W +: W];
            hz  = fwd_pending[i];
            return;
         end
      end
   endfunction

   logic [W-1:0] m_op1, m_op2, m_sd, m_cnt;
   logic         m_valid;
   int           m_cnt_sat;

   initial begin
      vecs[0] = '{2'd1, 2'd1, 5'd5, 5'd6, 32'h11, 32'h22, 3'b000, 15'd0, 96'd0,
                  32'h11, 32'h22, 32'h22, "no_match"};
      vecs[1] = '{2'd1, 2'd1, 5'd9, 5'd7, 32'h11, 32'h22, 3'b101, {5'd7, 5'd0, 5'd7},
                  {32'hC, 32'h0, 32'hA}, 32'h11, 32'hA, 32'hA, "priority"};
      vecs[2] = '{2'd1, 2'd1, 5'd5, 5'd7, 32'h11, 32'h22, 3'b110, {5'd7, 5'd5, 5'd0},
                  {32'hC, 32'hB, 32'h0}, 32'hB, 32'hC, 32'hC, "older_src"};
      vecs[3] = '{2'd1, 2'd1, 5'd0, 5'd0, 32'h11, 32'h22, 3'b001, 15'd0,
                  {32'h0, 32'h0, 32'hFF}, 32'h0, 32'h0, 32'h0, "x0"};
      vecs[4] = '{2'd2, 2'd2, 5'd5, 5'd6, 32'h11, 32'h22, 3'b000, 15'd0, 96'd0,
                  PC_V, IMM_V, 32'h22, "pc_imm"};
      vecs[5] = '{2'd3, 2'd3, 5'd5, 5'd6, 32'h11, 32'h22, 3'b000, 15'd0, 96'd0,
                  IMZ_V, 32'h0, 32'h22, "imz_illegal"};
      vecs[6] = '{2'd0, 2'd0, 5'd5, 5'd6, 32'h11, 32'h22, 3'b000, 15'd0, 96'd0,
                  32'h0, 32'h0, 32'h22, "sel_x"};

      idle();
      rst_n = 1'b0;
      #1;
      chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
      do_reset();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_op1", op1, 32'd0);
      chk("rst_stall", stall_count, 32'd0);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed vector table
      foreach (vecs[k]) begin
         op1_sel   = OP1_SEL'(vecs[k].s1);
         op2_sel   = OP2_SEL'(vecs[k].s2);
         rs1_addr  = vecs[k].a1;
         rs2_addr  = vecs[k].a2;
         rs1_data  = vecs[k].d1;
         rs2_data  = vecs[k].d2;
         fwd_valid = vecs[k].fv;
         fwd_rd    = vecs[k].frd;
         fwd_data  = vecs[k].fdat;
         rs1_use   = 1'b1;
         rs2_use   = 1'b1;
         in_valid  = 1'b1;
         #1;
         chk({vecs[k].name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
         tick();
         chk({vecs[k].name, "_valid"}, {31'd0, out_valid}, 32'd1);
         chk({vecs[k].name, "_op1"}, op1, vecs[k].e1);
         chk({vecs[k].name, "_op2"}, op2, vecs[k].e2);
         chk({vecs[k].name, "_sd"}, store_data, vecs[k].esd);
         in_valid = 1'b0;
         tick();
         chk({vecs[k].name, "_drain"}, {31'd0, out_valid}, 32'd0);
      end

      // Load-use stall then release
      do_reset();
      rs1_addr = 5'd3; rs1_use = 1'b1; op1_sel = OP1_RS1;
      fwd_valid = 3'b011; fwd_rd = {5'd0, 5'd3, 5'd3}; fwd_pending = 3'b001;
      fwd_data = {32'h0, 32'h77, 32'hDEAD};
      in_valid = 1'b1;
      #1;
      chk("lu_ready_c0", {31'd0, in_ready}, 32'd0);
      tick();
      chk("lu_ready_c1", {31'd0, in_ready}, 32'd0);
      chk("lu_valid_c1", {31'd0, out_valid}, 32'd0);
      tick();
      chk("lu_stall2", stall_count, 32'd2);
      fwd_pending = 3'b000; fwd_data = {32'h0, 32'h77, 32'h55};
      #1;
      chk("lu_ready_rel", {31'd0, in_ready}, 32'd1);
      tick();
      chk("lu_valid", {31'd0, out_valid}, 32'd1);
      chk("lu_op1", op1, 32'h55);
      chk("lu_stall_hold", stall_count, 32'd2);
      rs1_use = 1'b0; fwd_pending = 3'b001; op1_sel = OP1_PC;
      #1;
      chk("unused_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("unused_op1", op1, PC_V);
      chk("unused_stall", stall_count, 32'd2);

      // Saturation on the 3-bit counter instance
      do_reset();
      rs2_addr = 5'd4; rs2_use = 1'b1;
      fwd_valid = 3'b100; fwd_rd = {5'd4, 5'd0, 5'd0}; fwd_pending = 3'b100;
      in_valid = 1'b1;
      for (int c = 0; c < 9; c++) tick();
      chk("sat_wide", stall_count, 32'd9);
      chk("sat_narrow", {29'd0, stall_count_s}, 32'd7);

      // Backpressure then back-to-back
      do_reset();
      rs1_addr = 5'd5; rs1_data = 32'h11; rs1_use = 1'b1; in_valid = 1'b1;
      tick();
      chk("bp_first", op1, 32'h11);
      out_ready = 1'b0; rs1_data = 32'h33;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp_ready", {31'd0, in_ready}, 32'd0);
         tick();
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_op1_hold", op1, 32'h11);
      end
      out_ready = 1'b1;
      #1;
      chk("b2b_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_op1", op1, 32'h33);
      in_valid = 1'b0;
      tick();
      chk("b2b_drain", {31'd0, out_valid}, 32'd0);
      chk("b2b_data_hold", op1, 32'h33);

      // Flush with in_valid, from empty and from full under backpressure
      in_valid = 1'b1; flush = 1'b1; rs1_data = 32'h44;
      #1;
      chk("fl_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_no_capture", op1, 32'h33);
      flush = 1'b0;
      tick();
      chk("fl_refill", op1, 32'h44);
      out_ready = 1'b0; flush = 1'b1;
      tick();
      chk("fl_full_valid", {31'd0, out_valid}, 32'd0);
      flush = 1'b0; out_ready = 1'b1;

      // Reset in the middle of a stall with data held
      rs1_addr = 5'd6; fwd_valid = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd6}; fwd_pending = 3'b001;
      tick();
      tick();
      chk("rs_pre_stall", stall_count, 32'd2);
      rst_n = 1'b0;
      #1;
      chk("rs_ready_low", {31'd0, in_ready}, 32'd0);
      tick();
      chk("rs_valid", {31'd0, out_valid}, 32'd0);
      chk("rs_op1", op1, 32'd0);
      chk("rs_op2", op2, 32'd0);
      chk("rs_sd", store_data, 32'd0);
      chk("rs_stall", stall_count, 32'd0);

      // Randomized traffic against the reference model
      do_reset();
      m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_sd = '0; m_cnt = '0; m_cnt_sat = 0;
      for (int c = 0; c < 600; c++) begin
         logic [W-1:0] v1, v2, n1, n2;
         bit           h1, h2, hz, rdy;
         rst_n       = ($urandom_range(0, 49) != 0);
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 9) < 7);
         flush       = ($urandom_range(0, 19) == 0);
         op1_sel     = OP1_SEL'(2'($urandom_range(0, 3)));
         op2_sel     = OP2_SEL'(2'($urandom_range(0, 3)));
         rs1_use     = 1'($urandom_range(0, 1));
         rs2_use     = 1'($urandom_range(0, 1));
         rs1_addr    = 5'($urandom_range(0, 3));
         rs2_addr    = 5'($urandom_range(0, 3));
         rs1_data    = $urandom;
         rs2_data    = $urandom;
         pc          = $urandom;
         imm         = $urandom;
         imm_z_uext  = $urandom;
         fwd_valid   = 3'($urandom_range(0, 7));
         fwd_pending = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 3) == 0)};
         fwd_rd      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3))};
         fwd_data    = {$urandom, $urandom, $urandom};
         ref_resolve(rs1_addr, rs1_data, v1, h1);
         ref_resolve(rs2_addr, rs2_data, v2, h2);
         hz  = (rs1_use && h1) || (rs2_use && h2);
         rdy = rst_n && !flush && !hz && (!m_valid || out_ready);
         n1  = (op1_sel == OP1_RS1) ? v1 : (op1_sel == OP1_PC) ? pc :
               (op1_sel == OP1_IMZ) ? imm_z_uext : '0;
         n2  = (op2_sel == OP2_RS2) ? v2 : (op2_sel == OP2_IMM) ? imm : '0;
         #1;
         chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, rdy});
         tick();
         if (!rst_n) begin
            m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_sd = '0; m_cnt = '0; m_cnt_sat = 0;
         end else begin
            if (in_valid && hz && !flush) begin
               if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
               if (m_cnt_sat < 7) m_cnt_sat++;
            end
            if (flush) m_valid = 1'b0;
            else if (in_valid && rdy) begin
               m_valid = 1'b1; m_op1 = n1; m_op2 = n2; m_sd = v2;
            end else if (out_ready) m_valid = 1'b0;
         end
         chk("rnd_valid", {31'd0, out_valid}, {31'd0, m_valid});
         chk("rnd_op1", op1, m_op1);
         chk("rnd_op2", op2, m_op2);
         chk("rnd_sd", store_data, m_sd);
         chk("rnd_stall", stall_count, m_cnt);
         chk("rnd_stall_sat", {29'd0, stall_count_s}, 32'(m_cnt_sat));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
